// File: rtl/decoder_halt_sequencer_pkg.sv
// Shared definitions for the X1 opcode decoder HALT sequencer.
//   state_e       : sequencer states (IDLE, D0, D1, HALTED)
//   XPT_WIDTH_DEF : default width of the XPT T-state counter
//   XPT_D0/XPT_D1 : XPT values loaded on entry to D0 and D1
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D0     = 2'd1,
    ST_D1     = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int XPT_WIDTH_DEF = 5;
  localparam int XPT_D0        = 1;
  localparam int XPT_D1        = 2;

endpackage

// File: rtl/decoder_halt_sequencer_if.sv
// Bus between the timing generator / interrupt logic and the HALT sequencer.
//   master : drives enable, step, int_req, nmi_req, iff1; observes the rest
//   slave  : the sequencer; drives XPT, notXPT, decodedXPT, pulses, HALT state
interface decoder_halt_sequencer_if #(
  parameter int XPT_WIDTH    = 5,
  parameter int DECODE_DEPTH = 4
);
  logic                    enable;
  logic                    step;
  logic                    int_req;
  logic                    nmi_req;
  logic                    iff1;
  logic [XPT_WIDTH-1:0]    XPT;
  logic [XPT_WIDTH-1:0]    notXPT;
  logic [DECODE_DEPTH-1:0] decodedXPT;
  logic                    P2_Set_LHALT;
  logic                    PR_Reset_XPT;
  logic                    P2_Set_CM1;
  logic                    Pa_Ophd;
  logic                    m1_dummy;
  logic                    exit_halt;
  logic                    halted;
  logic                    notHALT;

  modport master (
    output enable, step, int_req, nmi_req, iff1,
    input  XPT, notXPT, decodedXPT, P2_Set_LHALT, PR_Reset_XPT, P2_Set_CM1,
           Pa_Ophd, m1_dummy, exit_halt, halted, notHALT
  );

  modport slave (
    input  enable, step, int_req, nmi_req, iff1,
    output XPT, notXPT, decodedXPT, P2_Set_LHALT, PR_Reset_XPT, P2_Set_CM1,
           Pa_Ophd, m1_dummy, exit_halt, halted, notHALT
  );
endinterface

// File: rtl/decoder_xpt_onehot.sv
// One-hot decode of an XPT T-state counter, shared by the X1 decoders.
//   en     : gates the whole decode (0 -> all strobes low)
//   xpt    : registered T-state count
//   onehot : onehot[i] = en && xpt == i; all zero when xpt >= DECODE_DEPTH
module decoder_xpt_onehot #(
  parameter int XPT_WIDTH    = 5,
  parameter int DECODE_DEPTH = 4
) (
  input  logic                    en,
  input  logic [XPT_WIDTH-1:0]    xpt,
  output logic [DECODE_DEPTH-1:0] onehot
);

  for (genvar i = 0; i < DECODE_DEPTH; i++) begin : g_dec
    assign onehot[i] = en && (xpt == XPT_WIDTH'(i));
  end

endmodule

// File: rtl/decoder_halt_sequencer.sv
// HALT execution sequencer for the opcode decoder.
// Runs the HALT opcode's closing T-states (D0, D1), then loops dummy M1
// cycles of M1_TSTATES T-states while halted. At the last T-state of each
// dummy M1 it checks NMI, or INT gated by iff1, and drops back to IDLE.
// All state advances only on CLK edges with step=1.
//   CLK      : system clock
//   notRESET : synchronous active-low reset
//   bus      : slave side of decoder_halt_sequencer_if (strobes + status)
module decoder_halt_sequencer
  import decoder_pkg::*;
#(
  parameter int XPT_WIDTH    = XPT_WIDTH_DEF,
  parameter int M1_TSTATES   = 4,
  parameter int DECODE_DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     notRESET,
  decoder_halt_sequencer_if.slave  bus
);

  localparam logic [XPT_WIDTH-1:0] XPT_LAST = XPT_WIDTH'(M1_TSTATES - 1);
  localparam logic [XPT_WIDTH-1:0] XPT_E0   = XPT_WIDTH'(XPT_D0);
  localparam logic [XPT_WIDTH-1:0] XPT_E1   = XPT_WIDTH'(XPT_D1);

  state_e               state;
  logic [XPT_WIDTH-1:0] xpt;
  logic                 halted;
  logic                 set_lhalt, rst_xpt, set_cm1, ophd, m1_dummy, exit_halt;
  logic                 exit_req;

  // NMI wins over INT, but both lead to the same single exit.
  assign exit_req = bus.nmi_req || (bus.int_req && bus.iff1);

  always_ff @(posedge CLK) begin
    if (!notRESET) begin
      state     <= ST_IDLE;
      xpt       <= '0;
      halted    <= 1'b0;
      set_lhalt <= 1'b0;
      rst_xpt   <= 1'b0;
      set_cm1   <= 1'b0;
      ophd      <= 1'b0;
      m1_dummy  <= 1'b0;
      exit_halt <= 1'b0;
    end else begin
      // Pulses live for exactly one CLK after the step that produced them.
      set_lhalt <= 1'b0;
      rst_xpt   <= 1'b0;
      set_cm1   <= 1'b0;
      ophd      <= 1'b0;
      m1_dummy  <= 1'b0;
      exit_halt <= 1'b0;
      if (bus.step) begin
        case (state)
          ST_IDLE: begin
            if (bus.enable) begin
              state     <= ST_D0;
              xpt       <= XPT_E0;
              set_lhalt <= 1'b1;
              halted    <= 1'b1;
            end
          end
          ST_D0: begin
            state   <= ST_D1;
            xpt     <= XPT_E1;
            rst_xpt <= 1'b1;
            set_cm1 <= 1'b1;
            ophd    <= 1'b1;
          end
          ST_D1: begin
            state    <= ST_HALTED;
            xpt      <= '0;
            m1_dummy <= 1'b1;
          end
          ST_HALTED: begin
            if (xpt == XPT_LAST) begin
              // Requests are only looked at here; nothing is latched earlier.
              xpt <= '0;
              if (exit_req) begin
                state     <= ST_IDLE;
                halted    <= 1'b0;
                exit_halt <= 1'b1;
              end else begin
                m1_dummy  <= 1'b1;
              end
            end else begin
              xpt <= xpt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  decoder_xpt_onehot #(
    .XPT_WIDTH   (XPT_WIDTH),
    .DECODE_DEPTH(DECODE_DEPTH)
  ) u_onehot (
    .en    (state != ST_IDLE),
    .xpt   (xpt),
    .onehot(bus.decodedXPT)
  );

  assign bus.XPT          = xpt;
  assign bus.notXPT       = ~xpt;
  assign bus.halted       = halted;
  assign bus.notHALT      = ~halted;
  assign bus.P2_Set_LHALT = set_lhalt;
  assign bus.PR_Reset_XPT = rst_xpt;
  assign bus.P2_Set_CM1   = set_cm1;
  assign bus.Pa_Ophd      = ophd;
  assign bus.m1_dummy     = m1_dummy;
  assign bus.exit_halt    = exit_halt;

endmodule

// File: doc/decoder_halt_sequencer.md
Name: decoder_halt_sequencer

Overview:
- Parametrised HALT execution sequencer for the opcode decoder.
- Owns its own T-state counter (XPT) and the HALT latch.
- Runs the HALT opcode's final T-states, then issues repeated dummy M1 cycles while halted, and releases on NMI or a maskable interrupt.
- Sits beside the X1 opcode decoders, driven by the timing generator's step strobe.

Parameters:
- XPT_WIDTH, 5, width of the XPT T-state counter.
- M1_TSTATES, 4, T-states per dummy M1 cycle while halted; legal range 2..2**XPT_WIDTH.
- DECODE_DEPTH, 4, number of one-hot decoded XPT strobes; legal range 1..2**XPT_WIDTH.

Ports:
- CLK  input  1  system clock.
- notRESET  input  1  synchronous, active-low reset.
- enable  input  1  HALT opcode decoded; sampled only in IDLE.
- step  input  1  T-state advance strobe; 0 freezes all state (wait states).
- int_req  input  1  maskable interrupt request, level.
- nmi_req  input  1  non-maskable interrupt request, level.
- iff1  input  1  interrupt enable flip-flop.
- XPT  output  XPT_WIDTH  current T-state count.
- notXPT  output  XPT_WIDTH  bitwise inverse of XPT.
- decodedXPT  output  DECODE_DEPTH  one-hot decode of XPT.
- P2_Set_LHALT  output  1  pulse: set HALT latch.
- PR_Reset_XPT  output  1  pulse: XPT reset.
- P2_Set_CM1  output  1  pulse: start M1.
- Pa_Ophd  output  1  pulse: opcode handled.
- m1_dummy  output  1  pulse at start of each dummy M1.
- exit_halt  output  1  pulse: halt released.
- halted  output  1  HALT latch.
- notHALT  output  1  external HALT, active-low.

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous, active-low on notRESET.
- Reset values: state=IDLE, XPT=0, notXPT=all ones, decodedXPT=0, all pulses 0, halted=0, notHALT=1.
- notRESET low mid-operation forces the reset values at the next edge, from any state.
- State register advances only on clock edges where step=1. Pulses are registered, one CLK wide, and asserted only on the edge where the step produced them.
- States are IDLE, D0, D1, HALTED.
- IDLE:
  - XPT holds 0.
  - enable=1 with step=1 -> D0, XPT=1.
- D0:
  - Assert P2_Set_LHALT.
  - Set halted=1; notHALT=~halted.
  - step -> D1, XPT=2.
- D1:
  - Assert PR_Reset_XPT, P2_Set_CM1 and Pa_Ophd together.
  - step -> HALTED, XPT=0, m1_dummy=1.
- HALTED:
  - XPT increments on each step, wrapping M1_TSTATES-1 -> 0.
  - m1_dummy pulses on every wrap to 0.
- Exit check: evaluated only on the step at XPT=M1_TSTATES-1.
  - nmi_req=1, or int_req=1 with iff1=1 -> IDLE, XPT=0, halted=0, exit_halt pulse, no m1_dummy.
  - NMI has priority; both requests together give a single exit.
  - int_req with iff1=0 is ignored.
  - Requests outside the check T-state are not latched; they must still be asserted at the check.
- enable is ignored outside IDLE.
- decodedXPT[i]=1 iff state!=IDLE and XPT==i. It is all zero for XPT>=DECODE_DEPTH. It is combinational from the registered XPT.
- Invariants: notXPT==~XPT always. At most one decodedXPT bit is set.

Decomposition:
- Shared package decoder_pkg holds:
  - the state enum (IDLE, D0, D1, HALTED);
  - default XPT_WIDTH;
  - localparam XPT_D0=1 and XPT_D1=2.
- One sub-module: decoder_xpt_onehot (XPT -> one-hot, parametrised by width and depth). It is reusable by the other X1 decoders.

Test Plan:
- Reset then idle: notRESET=0 for 2 CLK -> XPT=0, notXPT=5'b11111, notHALT=1. enable=0 with steps -> no pulses.
- HALT entry: enable=1,step=1 -> P2_Set_LHALT, then PR_Reset_XPT/P2_Set_CM1/Pa_Ophd together, then m1_dummy with XPT=0, halted=1, notHALT=0.
- Dummy loop with default M1_TSTATES=4: 12 steps in HALTED -> XPT cycles 0,1,2,3; m1_dummy every 4 steps; decodedXPT = 0001,0010,0100,1000.
- INT masking: int_req=1,iff1=0 for 8 steps -> stays HALTED. Set iff1=1 -> exit_halt at next XPT=3 step, halted=0, notHALT=1.
- NMI mid-M1 plus wait: nmi_req pulsed at XPT=1 only -> no exit. nmi_req held through XPT=3 with step=0 for 3 CLK -> exit only on the step edge.
- Reset mid-HALTED: notRESET=0 at XPT=2 -> IDLE, halted=0, no exit_halt. Rerun with M1_TSTATES=6, DECODE_DEPTH=2 -> wrap at 5, decodedXPT=0 for XPT>=2.
